// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit definitions: fun3 width codes, FSM states and the
// legality rule applied to an incoming memory op.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths exist only for loads; H/W must be naturally aligned.
    function automatic logic lsu_illegal(input logic load, input logic store,
                                         input logic [2:0] fun3, input logic [1:0] off);
        logic bad;
        case (fun3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = store;
            F3_H:    bad = off[0];
            F3_HU:   bad = store | off[0];
            F3_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        if (load && store) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte-enable/replicated data build, and
// load lane select with sign or zero extension.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_fun3,
    input  logic [1:0]  st_off,
    input  logic [31:0] store_data,
    input  logic [2:0]  ld_fun3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] ld_value
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wmask = 4'b1111;
        wdata = store_data;
        case (st_fun3)
            F3_B: begin
                wmask = 4'b0001 << st_off;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                wmask = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_fun3)
            F3_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_value = {24'h0, ld_byte};
            F3_H:    ld_value = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_value = {16'h0, ld_half};
            default: ld_value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: validates the op, runs one dmem req/ready access
// and returns extended load data; stall is held from accept until the access ends.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        Load,
    input  logic        Store,
    input  logic [2:0]  fun3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        lsu_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

    lsu_state_t  state, next_state;
    logic [29:0] cap_word;
    logic [1:0]  cap_off;
    logic [2:0]  cap_fun3;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wmask;
    logic [15:0] timer;
    logic        illegal_op, start, timeout_hit;
    logic [3:0]  new_wmask;
    logic [31:0] new_wdata, ld_value;

    load_store_unit_align u_align (
        .st_fun3    (fun3),
        .st_off     (addr[1:0]),
        .store_data (store_data),
        .ld_fun3    (cap_fun3),
        .ld_off     (cap_off),
        .rdata      (dmem_rdata),
        .wmask      (new_wmask),
        .wdata      (new_wdata),
        .ld_value   (ld_value)
    );

    assign illegal_op  = mem_en & (Load | Store) & lsu_illegal(Load, Store, fun3, addr[1:0]);
    assign start       = (state == ST_IDLE) & mem_en & (Load ^ Store) & ~illegal_op;
    // timer holds the number of REQ cycles already spent before this one
    assign timeout_hit = TO_EN & (state == ST_REQ) & ~dmem_ready & ((timer + 16'd1) == TO_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_REQ;
            ST_REQ: begin
                if (dmem_ready)       next_state = ST_DONE;
                else if (timeout_hit) next_state = ST_IDLE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        stall      = ((state == ST_IDLE) & start) | (state == ST_REQ);
        dmem_req   = (state == ST_REQ);
        dmem_we    = dmem_req & cap_we;
        dmem_addr  = dmem_req ? {cap_word, 2'b00} : 32'h0;
        dmem_wdata = dmem_req ? cap_wdata : 32'h0;
        dmem_wmask = dmem_req ? cap_wmask : 4'h0;
        load_valid = (state == ST_DONE) & ~cap_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_word  <= '0;
            cap_off   <= '0;
            cap_fun3  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            cap_wmask <= '0;
            timer     <= '0;
            load_data <= '0;
            lsu_fault <= 1'b0;
        end else begin
            lsu_fault <= ((state == ST_IDLE) & illegal_op) | timeout_hit;
            if (start) begin
                cap_word  <= addr[31:2];
                cap_off   <= addr[1:0];
                cap_fun3  <= fun3;
                cap_we    <= Store;
                cap_wdata <= Store ? new_wdata : 32'h0;
                cap_wmask <= Store ? new_wmask : 4'h0;
                timer     <= '0;
            end else if (state == ST_REQ) begin
                timer <= timer + 16'd1;
                if (dmem_ready && !cap_we) begin
                    load_data <= ld_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-addressed
// reference memory; a responder models the data memory with variable latency.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0, Load = 1'b0, Store = 1'b0;
    logic [2:0]  fun3 = 3'd0;
    logic [31:0] addr = 32'h0, store_data = 32'h0;
    logic        stall, load_valid, lsu_fault, dmem_req, dmem_we;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .Load(Load), .Store(Store),
        .fun3(fun3), .addr(addr), .store_data(store_data), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .lsu_fault(lsu_fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 memory access, 1 load result, 2 fault
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:31];
    logic [7:0]  ref_mem [0:127];
    int          resp_delay = 0;
    bit          hang = 1'b0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic take(input int kind, output exp_t e, output bit ok);
        checks++;
        ok = 1'b0;
        e  = '{default: '0};
        if (q.size() == 0 || q[0].kind != kind) begin
            errors++;
            $display("FAIL event_order actual_kind=%0d required_kind=%0d", kind,
                     (q.size() == 0) ? -1 : q[0].kind);
        end else begin
            e  = q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Monitor: every DUT-presented event must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (rst) begin
            if (dmem_req && dmem_ready) begin
                take(0, e, ok);
                if (ok) begin
                    check("dmem_addr", dmem_addr, e.addr);
                    check("dmem_we", {31'h0, dmem_we}, {31'h0, e.we});
                    check("dmem_wmask", {28'h0, dmem_wmask}, {28'h0, e.wmask});
                    if (e.we) check("dmem_wdata", dmem_wdata, e.wdata);
                end
            end
            if (load_valid) begin
                take(1, e, ok);
                if (ok) check("load_data", load_data, e.ldata);
            end
            if (lsu_fault) take(2, e, ok);
        end
    end

    // Data-memory responder: ready after resp_delay waiting cycles, masked writes.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst && dmem_req && !hang) begin
                if (wait_cnt == resp_delay) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = mem[dmem_addr[6:2]];
                    if (dmem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (dmem_wmask[i]) mem[dmem_addr[6:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
                    end
                    wait_cnt = 0;
                end else begin
                    dmem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
                wait_cnt   = 0;
            end
        end
    end

    function automatic int op_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Issue one op, push the architectural expectations, wait for completion.
    task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int dly, input bit no_ready);
        int          sz, off, base, req_cycles, n;
        bit          legal;
        exp_t        e;
        logic [31:0] v;
        sz    = op_size(f3);
        legal = (ld ^ st) && (sz != 0) && !(st && f3[2]) && !(ld && f3 == 3'b110);
        if (legal) legal = ((a % sz) == 0);
        off   = int'(a[1:0]);
        base  = int'(a) - 32'h100;
        e     = '{kind: 0, addr: {a[31:2], 2'b00}, we: st, wmask: 4'h0, wdata: 32'h0, ldata: 32'h0};
        if (!legal) begin
            e.kind = 2;
            q.push_back(e);
        end else if (no_ready) begin
            e.kind = 2;
            q.push_back(e);
        end else if (st) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + sz) e.wmask[i] = 1'b1;
                e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
            end
            for (int k = 0; k < sz; k++) ref_mem[base + k] = d[8*k +: 8];
            q.push_back(e);
        end else begin
            q.push_back(e);
            v = 32'h0;
            for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            e.kind  = 1;
            e.ldata = v;
            q.push_back(e);
        end
        resp_delay = dly;
        hang       = no_ready;
        @(posedge clk);
        #1;
        mem_en = 1'b1; Load = ld; Store = st; fun3 = f3; addr = a; store_data = d;
        @(negedge clk);
        check("stall_at_accept", {31'h0, stall}, {31'h0, legal});
        @(posedge clk);
        #1;
        mem_en = 1'b0; Load = 1'b0; Store = 1'b0; addr = $urandom; store_data = $urandom;
        if (legal) begin
            req_cycles = 0;
            n = 0;
            while (n < 50) begin
                @(negedge clk);
                if (!stall) break;
                if (dmem_req) req_cycles++;
                n++;
            end
            check("access_ends", {31'h0, stall}, 32'h0);
            check("req_cycles", req_cycles, no_ready ? 4 : dly + 1);
        end else begin
            @(negedge clk);
            check("illegal_no_req", {31'h0, dmem_req}, 32'h0);
            check("illegal_no_stall", {31'h0, stall}, 32'h0);
        end
        hang = 1'b0;
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        mem[idx] = w;
        for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = w[8*k +: 8];
    endtask

    initial begin
        bit          ld, st;
        logic [2:0]  f3;
        for (int i = 0; i < 32; i++) set_word(i, $urandom);
        set_word(0, 32'h12F0_3456);

        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_outputs", {30'h0, load_valid, lsu_fault}, 32'h0);
        #20;
        rst = 1'b1;

        issue(1, 0, 3'b000, 32'h102, 32'h0, 1, 0);
        check("lb_value_held", load_data, 32'hFFFF_FFF0);
        issue(1, 0, 3'b100, 32'h102, 32'h0, 0, 0);
        check("lbu_value_held", load_data, 32'h0000_00F0);
        issue(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 0);
        issue(0, 1, 3'b000, 32'h103, 32'h0000_00A5, 0, 0);
        check("sb_merged_word", mem[0], 32'hA5AD_BEEF);
        check("store_keeps_load_data", load_data, 32'h0000_00F0);
        issue(1, 0, 3'b001, 32'h101, 32'h0, 0, 0);
        issue(1, 1, 3'b010, 32'h108, 32'h0, 0, 0);
        issue(1, 0, 3'b010, 32'h104, 32'h0, 0, 1);
        issue(0, 1, 3'b001, 32'h10E, 32'h0000_C3B4, 2, 0);
        issue(1, 0, 3'b001, 32'h10E, 32'h0, 0, 0);
        check("lh_neg_value", load_data, 32'hFFFF_C3B4);

        // Async reset in the middle of an access, then a clean LW.
        hang = 1'b1;
        @(posedge clk);
        #1;
        mem_en = 1'b1; Load = 1'b1; fun3 = 3'b010; addr = 32'h104;
        @(posedge clk);
        #1;
        mem_en = 1'b0; Load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("arst_stall", {31'h0, stall}, 32'h0);
        check("arst_load_valid", {31'h0, load_valid}, 32'h0);
        #15;
        rst  = 1'b1;
        hang = 1'b0;
        issue(1, 0, 3'b010, 32'h104, 32'h0, 0, 0);

        for (int t = 0; t < 70; t++) begin
            st = $urandom_range(0, 1);
            ld = ~st;
            if ($urandom_range(0, 19) == 0) begin
                ld = 1'b1;
                st = 1'b1;
            end
            f3 = $urandom_range(0, 7);
            if ($urandom_range(0, 2) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            issue(ld, st, f3, 32'h100 + $urandom_range(0, 123), $urandom, $urandom_range(0, 3), 0);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
